// File: rtl/i2s_frame_sched_pkg.sv
// Shared types and frame-timing constants for the I2S frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_frame_sched_pkg;

  // Which source is driving the current wch1/wch2 pair.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_MIX  = 2'd3
  } src_t;

  localparam int         FRAME_MCLKS = 256;   // mclk cycles per stereo frame
  localparam int         SCLK_DIV    = 4;     // mclk cycles per sclk period
  localparam int         CNT_W       = 8;     // frame position counter width
  localparam logic [7:0] CAP_IDX     = 8'd255; // frame position where rx pair is published

  // Frame position at which the fetched pair becomes visible on wch1/wch2.
  function automatic logic [7:0] fetch_idx(input int prefetch);
    return 8'(FRAME_MCLKS - prefetch);
  endfunction

endpackage

// File: rtl/i2s_frame_sched_if.sv
// Sample-path bundle between the audio sources, the scheduler and the I2S2 driver.
// Latency: n/a (wires only).
// Backpressure: ready is an accept pulse from the scheduler; sources never stall it.
//   master: source/driver side (drives valids, samples, rch; sees readies, wch, rx)
//   slave : scheduler side
interface i2s_frame_sched_if #(
  parameter int N = 24
);
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_left;
  logic [N-1:0] a_right;

  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] b_left;
  logic [N-1:0] b_right;

  logic [N-1:0] wch1;
  logic [N-1:0] wch2;
  logic [N-1:0] rch1;
  logic [N-1:0] rch2;

  logic [N-1:0] rx_left;
  logic [N-1:0] rx_right;
  logic         rx_valid;

  modport master (
    output a_valid, a_left, a_right,
    output b_valid, b_left, b_right,
    output rch1, rch2,
    input  a_ready, b_ready,
    input  wch1, wch2,
    input  rx_left, rx_right, rx_valid
  );

  modport slave (
    input  a_valid, a_left, a_right,
    input  b_valid, b_left, b_right,
    input  rch1, rch2,
    output a_ready, b_ready,
    output wch1, wch2,
    output rx_left, rx_right, rx_valid
  );
endinterface

// File: rtl/i2s_frame_sched_clk_gen.sv
// Frame position counter with registered sclk (mclk/4) and lrclk (mclk/256).
// Latency: sclk/lrclk registered from the next counter value, so they track cnt exactly.
// Backpressure: none; en low parks the counter at 0 with both clocks low.
//   Ports: mclk, rst (sync, active-high), i_en; o_cnt frame position,
//   o_sclk/o_lrclk, o_fetch_stb/o_cap_stb one-cycle decision strobes.
module i2s_frame_sched_clk_gen
  import i2s_frame_sched_pkg::*;
#(
  parameter int PREFETCH = 16
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sclk,
  output logic             o_lrclk,
  output logic             o_fetch_stb,
  output logic             o_cap_stb
);

  // Strobes fire one cycle early so the scheduler's registered results
  // are visible exactly while cnt sits on the fetch / capture position.
  localparam logic [CNT_W-1:0] FETCH_PRE = fetch_idx(PREFETCH) - 8'd1;
  localparam logic [CNT_W-1:0] CAP_PRE   = CAP_IDX - 8'd1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             r_lrclk;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Natural 8-bit wrap gives the 255 -> 0 frame boundary.
  assign w_cnt_nxt = i_en ? r_cnt + 8'd1 : '0;

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_sclk  <= 1'b0;
      r_lrclk <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_sclk  <= w_cnt_nxt[1];
      r_lrclk <= w_cnt_nxt[7];
    end
  end

  assign o_cnt       = r_cnt;
  assign o_sclk      = r_sclk;
  assign o_lrclk     = r_lrclk;
  assign o_fetch_stb = i_en && (r_cnt == FETCH_PRE);
  assign o_cap_stb   = i_en && (r_cnt == CAP_PRE);

endmodule

// File: rtl/i2s_frame_sched.sv
// Per-frame scheduler: picks source A or B (or mixes them when MIX_SAT_EN is
// defined) onto the driver write channels and republishes the driver read pair.
// Latency: ready, wch and active_src are registered and appear while cnt == 256-PREFETCH;
//   rx pair and rx_valid appear while cnt == 255. Backpressure: none; sources get a
//   one-cycle accept pulse and are never waited on, an absent source counts as underrun.
//   Ports: mclk, rst (sync, active-high), i_en run enable, o_sclk/o_lrclk, o_frame_cnt,
//   o_active_src, o_underrun_cnt (saturating), io_bus (i2s_frame_sched_if.slave).
//   Optional macro: MIX_SAT_EN (both valid -> saturating per-channel sum, SRC_MIX).
module i2s_frame_sched
  import i2s_frame_sched_pkg::*;
#(
  parameter int N            = 24,
  parameter int STARVE_LIMIT = 4,
  parameter int PREFETCH     = 16,
  parameter int UCNT_W       = 16
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              i_en,
  output logic              o_sclk,
  output logic              o_lrclk,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output src_t              o_active_src,
  output logic [UCNT_W-1:0] o_underrun_cnt,
  i2s_frame_sched_if.slave  io_bus
);

  logic w_fetch_stb;
  logic w_cap_stb;

  i2s_frame_sched_clk_gen #(
    .PREFETCH (PREFETCH)
  ) u_clk_gen (
    .mclk        (mclk),
    .rst         (rst),
    .i_en        (i_en),
    .o_cnt       (o_frame_cnt),
    .o_sclk      (o_sclk),
    .o_lrclk     (o_lrclk),
    .o_fetch_stb (w_fetch_stb),
    .o_cap_stb   (w_cap_stb)
  );

  logic              r_a_ready;
  logic              r_b_ready;
  logic [N-1:0]      r_wch1;
  logic [N-1:0]      r_wch2;
  logic [N-1:0]      r_rx_left;
  logic [N-1:0]      r_rx_right;
  logic              r_rx_valid;
  src_t              r_src;
  logic [UCNT_W-1:0] r_ucnt;
  logic              r_first;   // suppresses the first capture after reset / en rise
  src_t              w_grant;

`ifdef MIX_SAT_EN
  // Signed add with clamp to the N-bit two's-complement range.
  function automatic logic [N-1:0] sat_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    s = {x[N-1], x} + {y[N-1], y};
    if (s[N] != s[N-1])
      return s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    return s[N-1:0];
  endfunction

  logic [N-1:0] w_mix_left;
  logic [N-1:0] w_mix_right;
  assign w_mix_left  = sat_add(io_bus.a_left,  io_bus.b_left);
  assign w_mix_right = sat_add(io_bus.a_right, io_bus.b_right);

  always_comb begin
    w_grant = SRC_NONE;
    if (io_bus.a_valid && io_bus.b_valid) w_grant = SRC_MIX;
    else if (io_bus.a_valid)              w_grant = SRC_A;
    else if (io_bus.b_valid)              w_grant = SRC_B;
  end
`else
  localparam int ST_W = $clog2(STARVE_LIMIT + 1);

  // Consecutive fetches at which B was valid but lost to A.
  logic [ST_W-1:0] r_starve;
  logic            w_starved;
  assign w_starved = (r_starve == ST_W'(STARVE_LIMIT));

  always_comb begin
    w_grant = SRC_NONE;
    if (io_bus.a_valid && !(io_bus.b_valid && w_starved)) w_grant = SRC_A;
    else if (io_bus.b_valid)                              w_grant = SRC_B;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_fetch_stb) begin
      if (w_grant == SRC_A && io_bus.b_valid)
        r_starve <= w_starved ? r_starve : r_starve + ST_W'(1);
      else
        r_starve <= '0;
    end
  end
`endif

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_a_ready  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_wch1     <= '0;
      r_wch2     <= '0;
      r_rx_left  <= '0;
      r_rx_right <= '0;
      r_rx_valid <= 1'b0;
      r_src      <= SRC_NONE;
      r_ucnt     <= '0;
      r_first    <= 1'b1;
    end else begin
      r_a_ready  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_rx_valid <= 1'b0;

      if (!i_en) r_first <= 1'b1;

      if (w_fetch_stb) begin
        r_src <= w_grant;
        case (w_grant)
          SRC_A: begin
            r_a_ready <= 1'b1;
            r_wch1    <= io_bus.a_left;
            r_wch2    <= io_bus.a_right;
          end
          SRC_B: begin
            r_b_ready <= 1'b1;
            r_wch1    <= io_bus.b_left;
            r_wch2    <= io_bus.b_right;
          end
`ifdef MIX_SAT_EN
          SRC_MIX: begin
            r_a_ready <= 1'b1;
            r_b_ready <= 1'b1;
            r_wch1    <= w_mix_left;
            r_wch2    <= w_mix_right;
          end
`endif
          default: begin
            // Underrun: play silence rather than repeating stale samples.
            r_wch1 <= '0;
            r_wch2 <= '0;
            if (r_ucnt != '1) r_ucnt <= r_ucnt + UCNT_W'(1);
          end
        endcase
      end

      if (w_cap_stb) begin
        if (r_first) begin
          // Driver has not completed a full frame yet; its read pair is junk.
          r_first <= 1'b0;
        end else begin
          r_rx_left  <= io_bus.rch1;
          r_rx_right <= io_bus.rch2;
          r_rx_valid <= 1'b1;
        end
      end
    end
  end

  assign io_bus.a_ready   = r_a_ready;
  assign io_bus.b_ready   = r_b_ready;
  assign io_bus.wch1      = r_wch1;
  assign io_bus.wch2      = r_wch2;
  assign io_bus.rx_left   = r_rx_left;
  assign io_bus.rx_right  = r_rx_right;
  assign io_bus.rx_valid  = r_rx_valid;
  assign o_active_src     = r_src;
  assign o_underrun_cnt   = r_ucnt;

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Randomised scoreboard bench for i2s_frame_sched: a frame-level model queues the
// expected grant and rx pair per frame; a negedge monitor compares every cycle.
module tb_i2s_frame_sched;

  localparam int N            = 24;
  localparam int STARVE_LIMIT = 4;
  localparam int PREFETCH     = 16;
  localparam int UCNT_W       = 2;
  localparam int FETCH_IDX    = 256 - PREFETCH;
  localparam int UMAX         = (1 << UCNT_W) - 1;

  localparam logic [1:0] S_NONE = 2'd0;
  localparam logic [1:0] S_A    = 2'd1;
  localparam logic [1:0] S_B    = 2'd2;
  localparam logic [1:0] S_MIX  = 2'd3;

  typedef struct {
    logic              ar;
    logic              br;
    logic [1:0]        src;
    logic [N-1:0]      w1;
    logic [N-1:0]      w2;
    logic [UCNT_W-1:0] ucnt;
  } fexp_t;

  typedef struct {
    logic         vld;
    logic [N-1:0] l;
    logic [N-1:0] r;
  } rexp_t;

  logic              mclk;
  logic              rst;
  logic              en;
  logic              sclk;
  logic              lrclk;
  logic [7:0]        fcnt;
  logic [1:0]        asrc;
  logic [UCNT_W-1:0] ucnt;

  i2s_frame_sched_if #(.N(N)) bus ();

  i2s_frame_sched #(
    .N            (N),
    .STARVE_LIMIT (STARVE_LIMIT),
    .PREFETCH     (PREFETCH),
    .UCNT_W       (UCNT_W)
  ) dut (
    .mclk           (mclk),
    .rst            (rst),
    .i_en           (en),
    .o_sclk         (sclk),
    .o_lrclk        (lrclk),
    .o_frame_cnt    (fcnt),
    .o_active_src   (asrc),
    .o_underrun_cnt (ucnt),
    .io_bus         (bus)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Bench-side view of frame position: cycles since enable, modulo 256.
  logic [7:0] m_cnt   = 8'd0;
  bit         started = 1'b0;
  bit         rst_q   = 1'b0;

  always @(posedge mclk) begin
    started <= 1'b1;
    rst_q   <= rst;
    if (rst || !en) m_cnt <= 8'd0;
    else            m_cnt <= m_cnt + 8'd1;
  end

  fexp_t fq[$];
  rexp_t rq[$];

  // Reference state at frame granularity.
  int                b_denied = 0;   // consecutive contested frames B has lost
  int                ucnt_m   = 0;
  bit                first    = 1'b1;

`ifdef MIX_SAT_EN
  function automatic logic [N-1:0] sat(input logic [N-1:0] x, input logic [N-1:0] y);
    int sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    s  = sx + sy;
    if (s >  8388607) s =  8388607;
    if (s < -8388608) s = -8388608;
    return s[N-1:0];
  endfunction
`endif

  task automatic wait_cnt(input logic [7:0] v);
    int n = 0;
    do begin
      @(posedge mclk);
      #1;
      n++;
    end while (m_cnt != v && n < 1000);
    if (m_cnt != v) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: frame position %0d not reached within 1000 cycles", v);
    end
  endtask

  // Present one frame's worth of source/driver inputs and queue the expected outcome.
  task automatic do_frame(input bit av, input bit bv,
                          input logic [N-1:0] al, input logic [N-1:0] ar,
                          input logic [N-1:0] bl, input logic [N-1:0] br,
                          input logic [N-1:0] r1, input logic [N-1:0] r2);
    fexp_t e;
    rexp_t r;
    wait_cnt(8'd100);
    bus.a_valid = av; bus.a_left = al; bus.a_right = ar;
    bus.b_valid = bv; bus.b_left = bl; bus.b_right = br;
    bus.rch1    = r1; bus.rch2   = r2;

    e.ar = 1'b0; e.br = 1'b0; e.src = S_NONE; e.w1 = '0; e.w2 = '0;
    if (av && bv) begin
`ifdef MIX_SAT_EN
      e.ar = 1'b1; e.br = 1'b1; e.src = S_MIX; e.w1 = sat(al, bl); e.w2 = sat(ar, br);
`else
      if (b_denied == STARVE_LIMIT) begin e.br = 1'b1; e.src = S_B; e.w1 = bl; e.w2 = br; end
      else                          begin e.ar = 1'b1; e.src = S_A; e.w1 = al; e.w2 = ar; end
`endif
    end else if (av) begin
      e.ar = 1'b1; e.src = S_A; e.w1 = al; e.w2 = ar;
    end else if (bv) begin
      e.br = 1'b1; e.src = S_B; e.w1 = bl; e.w2 = br;
    end else begin
      ucnt_m = (ucnt_m == UMAX) ? UMAX : ucnt_m + 1;
    end

    if (bv && e.src == S_A) b_denied = (b_denied == STARVE_LIMIT) ? STARVE_LIMIT : b_denied + 1;
    else                    b_denied = 0;

    e.ucnt = UCNT_W'(ucnt_m);
    fq.push_back(e);

    r.vld = !first; r.l = r1; r.r = r2;
    rq.push_back(r);
    first = 1'b0;
  endtask

  task automatic rand_frame();
    do_frame($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             N'($urandom()), N'($urandom()), N'($urandom()), N'($urandom()),
             N'($urandom()), N'($urandom()));
  endtask

  // Monitor: expected values held between events, compared every cycle.
  logic [N-1:0]      h_w1, h_w2, h_rxl, h_rxr;
  logic [1:0]        h_src;
  logic [UCNT_W-1:0] h_ucnt;
  logic              e_ar, e_br, e_rxv;
  fexp_t             mf;
  rexp_t             mr;

  always @(negedge mclk) begin
    if (started) begin
      if (rst_q) begin
        h_w1 = '0; h_w2 = '0; h_rxl = '0; h_rxr = '0; h_src = S_NONE; h_ucnt = '0;
      end
      e_ar = 1'b0; e_br = 1'b0; e_rxv = 1'b0;
      if (!rst_q && m_cnt == 8'(FETCH_IDX)) begin
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_queue at t=%0t: fetch point reached with no expected grant", $time);
        end else begin
          mf = fq.pop_front();
          e_ar = mf.ar; e_br = mf.br; h_src = mf.src; h_w1 = mf.w1; h_w2 = mf.w2; h_ucnt = mf.ucnt;
        end
      end
      if (!rst_q && m_cnt == 8'd255) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_queue at t=%0t: capture point reached with no expected rx pair", $time);
        end else begin
          mr = rq.pop_front();
          e_rxv = mr.vld;
          if (mr.vld) begin h_rxl = mr.l; h_rxr = mr.r; end
        end
      end
      chk("frame_cnt",    fcnt,         m_cnt);
      chk("sclk",         sclk,         m_cnt[1]);
      chk("lrclk",        lrclk,        m_cnt[7]);
      chk("a_ready",      bus.a_ready,  e_ar);
      chk("b_ready",      bus.b_ready,  e_br);
      chk("wch1",         bus.wch1,     h_w1);
      chk("wch2",         bus.wch2,     h_w2);
      chk("active_src",   asrc,         h_src);
      chk("underrun_cnt", ucnt,         h_ucnt);
      chk("rx_valid",     bus.rx_valid, e_rxv);
      chk("rx_left",      bus.rx_left,  h_rxl);
      chk("rx_right",     bus.rx_right, h_rxr);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0;
    bus.a_valid = 1'b0; bus.a_left = '0; bus.a_right = '0;
    bus.b_valid = 1'b0; bus.b_left = '0; bus.b_right = '0;
    bus.rch1 = '0; bus.rch2 = '0;
    repeat (4) @(posedge mclk);
    #1 rst = 1'b0;
    repeat (5) begin @(posedge mclk); #1; end

    // Source A only, fixed pattern; driver read pair held.
    en = 1'b1; first = 1'b1;
    repeat (4) do_frame(1'b1, 1'b0, 24'h123456, 24'hABCDEF,
                        N'($urandom()), N'($urandom()), 24'h00000F, 24'h800000);

    // Both sources valid: B forced through every STARVE_LIMIT+1 contested frames.
    for (int i = 0; i < 10; i++)
      do_frame(1'b1, 1'b1, N'($urandom()), N'($urandom()), N'($urandom()), N'($urandom()),
               24'h00000F, 24'h800000);

    // Nothing valid: silence and a saturating underrun count.
    repeat (5) do_frame(1'b0, 1'b0, N'($urandom()), N'($urandom()), N'($urandom()), N'($urandom()),
                        N'($urandom()), N'($urandom()));

    // Disable mid-frame: clocks park, outputs hold, first capture suppressed on restart.
    wait_cnt(8'd50);
    en = 1'b0;
    repeat (40) begin @(posedge mclk); #1; end
    en = 1'b1; first = 1'b1;

    for (int i = 0; i < 30; i++) rand_frame();

    // Saturation corner samples.
    do_frame(1'b1, 1'b1, 24'h7FFFF0, 24'h800000, 24'h000020, 24'hFFFFFF,
             N'($urandom()), N'($urandom()));

    // Reset on the edge that would have produced a fetch, with both sources valid.
    wait_cnt(8'd255);
    wait_cnt(8'd239);
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    rst = 1'b1;
    @(posedge mclk);
    #1 rst = 1'b0;
    b_denied = 0; ucnt_m = 0; first = 1'b1;

    repeat (3) rand_frame();

    wait_cnt(8'd255);
    @(negedge mclk);
    #1;
    chk("fetch_queue_drained", fq.size(), 0);
    chk("rx_queue_drained",    rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
